// File: rtl/filt_ppi_pkg.sv
// Shared types and helpers for the polyphase interpolation FIR and its scheduler.
// The commutator map lives here so the filter and scheduler cannot disagree on bank order.
package filt_ppi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } sched_state_t;

  function automatic int unsigned f_ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Operands stay below 2*L, so a single conditional subtract is the full modulo.
  function automatic int unsigned f_phase_map(
    input int unsigned cnt,
    input int unsigned l,
    input int unsigned ofs,
    input logic        ccw
  );
    int unsigned s;
    s = ccw ? (cnt + ofs) : (ofs + l - cnt);
    if (s >= l) s = s - l;
    return s;
  endfunction

endpackage

// File: rtl/filt_ppi_phase_cnt.sv
// Mod-L phase counter with commutator direction/offset mapping.
// Clear has priority over advance so the counter parks at 0 outside RUN.
module filt_ppi_phase_cnt
  import filt_ppi_pkg::*;
#(
  parameter int gp_interpolation_factor = 4,
  parameter int gp_comm_ccw             = 1,
  parameter int gp_comm_phase           = 0
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_an,
  input  logic                                       i_clr,
  input  logic                                       i_adv,
  output logic [$clog2(gp_interpolation_factor)-1:0] o_cnt,
  output logic [$clog2(gp_interpolation_factor)-1:0] o_phase
);

  localparam int L  = gp_interpolation_factor;
  localparam int PW = $clog2(L);

  logic [PW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == PW'(L - 1));

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_adv) begin
      r_cnt <= w_wrap ? '0 : r_cnt + PW'(1);
    end
  end

  assign o_cnt   = r_cnt;
  assign o_phase = PW'(f_phase_map(32'(r_cnt), L, gp_comm_phase, gp_comm_ccw != 0));

endmodule

// File: rtl/filt_ppi_sched.sv
// Output-rate scheduler for filt_ppi: one input slot per L fast cycles, load strobe,
// commutator phase, warm-up (ovalid) and sticky underflow tracking.
module filt_ppi_sched
  import filt_ppi_pkg::*;
#(
  parameter int gp_idata_width          = 16,
  parameter int gp_interpolation_factor = 4,
  parameter int gp_coeff_length         = 32,
  parameter int gp_comm_ccw             = 1,
  parameter int gp_comm_phase           = 0
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_an,
  input  logic                                       i_ena,
  input  logic                                       i_valid,
  input  logic [gp_idata_width-1:0]                  i_data,
  input  logic                                       i_clr_flag,
  output logic                                       o_ready,
  output logic [gp_idata_width-1:0]                  o_data,
  output logic                                       o_load,
  output logic [$clog2(gp_interpolation_factor)-1:0] o_phase,
  output logic                                       o_ovalid,
  output logic                                       o_underflow,
  output logic [1:0]                                 o_dbg_state
);

  // Handshake: a sample transfers on a rising i_clk edge where i_valid && o_ready
  // (and i_ena). o_ready depends only on registered state, never on i_valid.

  localparam int          L   = gp_interpolation_factor;
  localparam int          PW  = $clog2(L);
  localparam int unsigned T   = f_ceil_div(gp_coeff_length, L);
  localparam int          LCW = $clog2(T + 1);

  sched_state_t              r_state;
  logic [gp_idata_width-1:0] r_data;
  logic                      r_load;
  logic                      r_ovalid;
  logic                      r_underflow;
  logic [LCW-1:0]            r_load_cnt;

  logic [PW-1:0]  w_cnt;
  logic [PW-1:0]  w_phase;
  logic           w_run;
  logic           w_sync;
  logic           w_ready;
  logic           w_slot;
  logic           w_load_nxt;
  logic           w_uflow_set;
  logic           w_cnt_clr;
  logic           w_cnt_adv;
  logic [LCW-1:0] w_load_cnt_nxt;

  assign w_run  = (r_state == RUN);
  assign w_sync = (r_state == SYNC);

  filt_ppi_phase_cnt #(
    .gp_interpolation_factor (L),
    .gp_comm_ccw             (gp_comm_ccw),
    .gp_comm_phase           (gp_comm_phase)
  ) u_phase_cnt (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .i_clr    (w_cnt_clr),
    .i_adv    (w_cnt_adv),
    .o_cnt    (w_cnt),
    .o_phase  (w_phase)
  );

  // Dropping i_ena also clears the counter so IDLE starts from phase offset next cycle.
  assign w_cnt_adv = i_ena && w_run;
  assign w_cnt_clr = !w_cnt_adv;

  assign w_ready = w_sync || (w_run && (w_cnt == PW'(L - 1)));
  assign w_slot  = w_ready && i_ena;

  // In RUN every slot loads (zero-stuffed if empty); in SYNC only a real sample loads.
  assign w_load_nxt  = w_slot && (i_valid || w_run);
  assign w_uflow_set = w_slot && w_run && !i_valid;

  assign w_load_cnt_nxt = (w_load_nxt && (r_load_cnt != LCW'(T))) ?
                          r_load_cnt + LCW'(1) : r_load_cnt;

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_load      <= 1'b0;
      r_ovalid    <= 1'b0;
      r_underflow <= 1'b0;
      r_load_cnt  <= '0;
    end else begin
      // Sticky flag survives leaving RUN; a new underflow beats a same-cycle clear.
      if (w_uflow_set) begin
        r_underflow <= 1'b1;
      end else if (i_clr_flag) begin
        r_underflow <= 1'b0;
      end

      if (!i_ena) begin
        r_state    <= IDLE;
        r_data     <= '0;
        r_load     <= 1'b0;
        r_ovalid   <= 1'b0;
        r_load_cnt <= '0;
      end else begin
        case (r_state)
          IDLE:    r_state <= SYNC;
          SYNC:    if (i_valid) r_state <= RUN;
          RUN:     r_state <= RUN;
          default: r_state <= IDLE;
        endcase

        r_load <= w_load_nxt;
        if (w_load_nxt) begin
          r_data <= i_valid ? i_data : '0;
        end
        r_load_cnt <= w_load_cnt_nxt;
        r_ovalid   <= (w_load_cnt_nxt == LCW'(T));
      end
    end
  end

  assign o_ready     = w_ready;
  assign o_data      = r_data;
  assign o_load      = r_load;
  assign o_phase     = w_phase;
  assign o_ovalid    = r_ovalid;
  assign o_underflow = r_underflow;
  assign o_dbg_state = r_state;

endmodule

// File: doc/filt_ppi_sched.md
# filt_ppi_sched

Fast-rate scheduler for the polyphase interpolation FIR (`filt_ppi`). It runs entirely on the output-rate clock and accepts input samples through a valid/ready handshake, exactly once every `gp_interpolation_factor` cycles. It drives the load strobe and the commutator phase index that sequence the filter's polyphase branches. It also flags warm-up completion and input underflow.

## Interface
Parameters:
- `gp_idata_width`, 16, input sample width.
- `gp_interpolation_factor` (L), 4, number of polyphase branches; must be ≥2.
- `gp_coeff_length`, 32, prototype filter length; taps per phase T = ceil(`gp_coeff_length`/L).
- `gp_comm_ccw`, 1, commutator direction: 1 = counter-clockwise, 0 = clockwise.
- `gp_comm_phase`, 0, phase offset added to the commutator index; range 0..L-1.

Ports:
- `i_clk`, in, 1: output-rate (fast) clock; the only clock.
- `i_rst_an`, in, 1: asynchronous active-low reset.
- `i_ena`, in, 1: block enable; low forces IDLE.
- `i_valid`, in, 1: input sample valid.
- `i_data`, in, `gp_idata_width`, signed input sample.
- `i_clr_flag`, in, 1: clears the sticky underflow flag.
- `o_ready`, out, 1: sample slot open.
- `o_data`, out, `gp_idata_width`, registered sample presented to the filter.
- `o_load`, out, 1: one-cycle strobe; the filter shifts `o_data` into its delay line.
- `o_phase`, out, clog2(L), commutator / coefficient-bank index.
- `o_ovalid`, out, 1: filter output is valid (warm-up done).
- `o_underflow`, out, 1: sticky; an input slot passed without a valid sample.

## Operation
- States:
  - IDLE: `i_ena`=0.
  - SYNC: enabled, waiting for the first sample.
  - RUN: steady state.
- State transitions:
  - IDLE→SYNC when `i_ena`=1.
  - SYNC→RUN on the first `i_valid`&&`o_ready`.
  - Any state→IDLE when `i_ena`=0.
- Phase counter `cnt`:
  - Runs 0..L-1 and wraps, advancing every cycle in RUN.
  - Forced to 0 in IDLE and SYNC.
- `o_ready` = (state==SYNC) || (state==RUN && `cnt`==L-1). This is combinational from registered state.
- Slot event = `o_ready` in RUN or SYNC. At a slot event, the next cycle has:
  - `o_load`=1.
  - If `i_valid`: `o_data` = `i_data`.
  - If not `i_valid` in RUN: `o_data` = 0, zero-stuff, and `o_underflow` is set.
  - If not `i_valid` in SYNC: no load.
- `o_phase`:
  - CCW: (`cnt` + `gp_comm_phase`) mod L.
  - CW: (`gp_comm_phase` − `cnt`) mod L.
  - Arithmetic is done in clog2(L)+1 bits before the modulo.
- Load counter:
  - Counts `o_load` pulses and saturates at T.
  - `o_ovalid` rises in the cycle of the T-th `o_load` and stays high while in RUN.
  - Zero-stuffed loads count toward T.
- Underflow flag:
  - Set and `i_clr_flag` in the same cycle: set wins.
  - Not cleared by leaving RUN; cleared only by reset or `i_clr_flag`.

## Timing
- Reset values: `o_ready`=0, `o_data`=0, `o_load`=0, `o_phase`=`gp_comm_phase`, `o_ovalid`=0, `o_underflow`=0.
- Internal reset values: state=IDLE, `cnt`=0, load counter=0.
- Latency from accepted sample to `o_load`/`o_data`: 1 cycle.
- In RUN, `o_load` pulses exactly every L cycles, in the cycle where `cnt`=0.
- In RUN, `o_phase` walks L values per input sample.
- `i_ena` falling mid-RUN, next cycle:
  - IDLE, `cnt`=0, load counter=0.
  - `o_ovalid`=0, `o_load`=0, `o_data`=0.
  - `o_underflow` is held.
- `i_ena` re-asserted: restarts through SYNC, and warm-up repeats.
- Asynchronous reset mid-operation: all outputs take their reset values immediately.
- Deassertion of reset is synchronised externally.

## Structure
- Package `filt_ppi_pkg` holds:
  - state enum `sched_state_t` {IDLE, SYNC, RUN}.
  - function `f_ceil_div` for T.
  - function `f_phase_map`, the commutator index map, shared with `filt_ppi`.
- Sub-module `filt_ppi_phase_cnt` is the mod-L counter with direction/offset mapping, producing `cnt` and `o_phase`.
- The top level holds the FSM, handshake, load counter and flags.

## Test plan
All scenarios use defaults: L=4, `gp_coeff_length`=32, T=8.
- Reset then `i_ena`=1, `i_valid` held 1 with `i_data`=1,2,3…:
  - Samples accepted only at `o_ready`.
  - `o_load` every 4 cycles.
  - `o_data` = 1,2,3….
  - `o_ovalid` rises with the 8th load, and `o_underflow` stays 0.
- CCW, `gp_comm_phase`=1: `o_phase` sequence per sample is 1,2,3,0. CW, offset 0: the sequence is 0,3,2,1.
- Drop `i_valid` for one slot in RUN:
  - That load has `o_data`=0.
  - `o_underflow`=1 from the next cycle.
  - The cadence of `o_load` is unchanged.
- `i_clr_flag` pulsed in the same cycle as a new underflow: `o_underflow` remains 1. A clear in a later, clean cycle gives `o_underflow`=0.
- `i_ena` low for 3 cycles after the 5th load:
  - `o_ovalid`=0 and `o_phase`=`gp_comm_phase`.
  - On re-enable, `o_ovalid` rises only after 8 new loads.
- `i_rst_an` asserted mid-RUN (between clock edges): all outputs are at reset values before the next `i_clk` edge.
